// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage: register file, immediate extension, destination select, ID/EX register
// Optional feature macro ID_WB_BYPASS_EN: write-first forwarding of the WB write into the captured read data.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            in_valid,
  input  logic [31:0]     Ins,
  input  logic            stall,
  input  logic            flush,
  input  logic            WE,
  input  logic [AW-1:0]   Wadr,
  input  logic [XLEN-1:0] Wdata,
  output logic            out_valid,
  output logic [XLEN-1:0] Rdata1,
  output logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] Ed32,
  output logic [AW-1:0]   Dadr,
  output logic [5:0]      op_out,
  output logic [5:0]      funct_out
);

  localparam logic [5:0] OP_RFORM = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [AW-1:0]   rs;
  logic [AW-1:0]   rt;
  logic [AW-1:0]   rd;
  logic [15:0]     imm;
  logic            unused_ins;

  // Register fields are truncated to AW bits so smaller files alias cleanly.
  assign op         = Ins[31:26];
  assign rs         = Ins[21 +: AW];
  assign rt         = Ins[16 +: AW];
  assign rd         = Ins[11 +: AW];
  assign imm        = Ins[15:0];
  assign funct      = Ins[5:0];
  assign unused_ins = ^Ins;

  logic [XLEN-1:0] regs [NREG];
  logic            wr_en;

  assign wr_en = WE && (Wadr != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Wadr] <= Wdata;
    end
  end

  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] ext;
  logic [AW-1:0]   dst;

  always_comb begin
    rd1 = (rs == '0) ? '0 : regs[rs];
    rd2 = (rt == '0) ? '0 : regs[rt];
`ifdef ID_WB_BYPASS_EN
    // wr_en already excludes r0, so address 0 is never forwarded.
    if (wr_en && (Wadr == rs)) rd1 = Wdata;
    if (wr_en && (Wadr == rt)) rd2 = Wdata;
`endif
  end

  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: ext = XLEN'(imm);
      OP_LUI:                   ext = XLEN'({imm, 16'h0000});
      default:                  ext = XLEN'($signed(imm));
    endcase
  end

  always_comb begin
    case (op)
      OP_JAL:   dst = AW'(NREG - 1);
      OP_RFORM: dst = rd;
      default:  dst = rt;
    endcase
  end

  // Flush wins over stall; data still loads on flush since out_valid marks it dead.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      Rdata1    <= '0;
      Rdata2    <= '0;
      Ed32      <= '0;
      Dadr      <= '0;
      op_out    <= '0;
      funct_out <= '0;
    end else if (flush || !stall) begin
      out_valid <= flush ? 1'b0 : in_valid;
      Rdata1    <= rd1;
      Rdata2    <= rd2;
      Ed32      <= ext;
      Dadr      <= dst;
      op_out    <= op;
      funct_out <= funct;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized checks of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            in_valid;
  logic [31:0]     Ins;
  logic            stall;
  logic            flush;
  logic            WE;
  logic [AW-1:0]   Wadr;
  logic [XLEN-1:0] Wdata;
  logic            out_valid;
  logic [XLEN-1:0] Rdata1;
  logic [XLEN-1:0] Rdata2;
  logic [XLEN-1:0] Ed32;
  logic [AW-1:0]   Dadr;
  logic [5:0]      op_out;
  logic [5:0]      funct_out;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .Ins(Ins), .stall(stall), .flush(flush),
    .WE(WE), .Wadr(Wadr), .Wdata(Wdata), .out_valid(out_valid), .Rdata1(Rdata1),
    .Rdata2(Rdata2), .Ed32(Ed32), .Dadr(Dadr), .op_out(op_out), .funct_out(funct_out)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_reg [32];
  logic        m_valid;
  logic [31:0] m_r1, m_r2, m_ed;
  logic [4:0]  m_dadr;
  logic [5:0]  m_op, m_funct;
  bit          m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_known) begin
      chk({tag, ".rdata1"}, Rdata1, m_r1);
      chk({tag, ".rdata2"}, Rdata2, m_r2);
      chk({tag, ".ed32"}, Ed32, m_ed);
      chk({tag, ".dadr"}, 32'(Dadr), 32'(m_dadr));
      chk({tag, ".op"}, 32'(op_out), 32'(m_op));
      chk({tag, ".funct"}, 32'(funct_out), 32'(m_funct));
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [15:0] imm);
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return 32'(imm);
    if (op == 6'h0F) return 32'(imm) * 32'd65536;
    return imm[15] ? 32'(imm) - 32'h0001_0000 : 32'(imm);
  endfunction

  function automatic logic [4:0] ref_dadr(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
    if (op == 6'h03) return 5'(NREG - 1);
    if (op == 6'h00) return rd;
    return rt;
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_reg[i] = 32'h0;
    m_valid = 1'b0; m_r1 = '0; m_r2 = '0; m_ed = '0; m_dadr = '0; m_op = '0; m_funct = '0;
    m_known = 1'b1;
  endtask

  // One clock: drive inputs, predict, clock, compare 1 time unit after the edge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic st,
                      input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] r1, r2;
    in_valid = v; Ins = ins; stall = st; flush = fl; WE = we; Wadr = wa; Wdata = wd;
    r1 = ref_reg[ins[25:21]];
    r2 = ref_reg[ins[20:16]];
`ifdef ID_WB_BYPASS_EN
    if (we && wa != 5'd0 && wa == ins[25:21]) r1 = wd;
    if (we && wa != 5'd0 && wa == ins[20:16]) r2 = wd;
`endif
    @(posedge CLK);
    if (fl) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end else if (!st) begin
      m_valid = v; m_known = 1'b1;
      m_r1 = r1; m_r2 = r2;
      m_ed = ref_ext(ins[31:26], ins[15:0]);
      m_dadr = ref_dadr(ins[31:26], ins[20:16], ins[15:11]);
      m_op = ins[31:26]; m_funct = ins[5:0];
    end
    if (we && wa != 5'd0) ref_reg[wa] = wd;
    #1;
    check_all(tag);
  endtask

  logic [5:0]  ops [8];
  logic [31:0] rins;

  initial begin
    ops = '{6'h00, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23};
    RST_N = 1'b0; in_valid = 0; Ins = '0; stall = 0; flush = 0; WE = 0; Wadr = '0; Wdata = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;

    step("wr10", 0, '0, 0, 0, 1, 5'd10, 32'd86);
    step("rd10", 1, mk_i(6'h08, 5'd10, 5'd0, 16'h0004), 0, 0, 0, 5'd0, 32'd0);
    chk("rd10.direct", Rdata1, 32'd86);
    step("wr0", 0, '0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
    step("rd0", 1, mk_i(6'h23, 5'd0, 5'd0, 16'h0000), 0, 0, 0, 5'd0, 32'd0);
    chk("rd0.direct", Rdata1, 32'd0);

    step("ori", 1, mk_i(6'h0D, 5'd1, 5'd2, 16'h8001), 0, 0, 0, 5'd0, 32'd0);
    chk("ori.direct", Ed32, 32'h0000_8001);
    step("addi", 1, mk_i(6'h08, 5'd1, 5'd2, 16'h8001), 0, 0, 0, 5'd0, 32'd0);
    chk("addi.direct", Ed32, 32'hFFFF_8001);
    step("lui", 1, mk_i(6'h0F, 5'd0, 5'd3, 16'h1234), 0, 0, 0, 5'd0, 32'd0);
    chk("lui.direct", Ed32, 32'h1234_0000);
    step("jal", 1, {6'h03, 26'h123_4567}, 0, 0, 0, 5'd0, 32'd0);
    chk("jal.direct", 32'(Dadr), 32'd31);
    step("rform", 1, mk_r(5'd10, 5'd4, 5'd9, 6'h20), 0, 0, 0, 5'd0, 32'd0);
    chk("rform.direct", 32'(Dadr), 32'd9);

    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 1, $urandom, 1, 0, 1, 5'(i + 20), $urandom);
    step("stall_rd", 1, mk_r(5'd20, 5'd21, 5'd1, 6'h21), 0, 0, 0, 5'd0, 32'd0);
    step("stall_flush", 1, mk_r(5'd22, 5'd0, 5'd1, 6'h22), 1, 1, 0, 5'd0, 32'd0);
    chk("stall_flush.direct", 32'(out_valid), 32'd0);

    step("haz_pre", 0, '0, 0, 0, 1, 5'd11, 32'd5);
    step("haz", 1, mk_i(6'h08, 5'd11, 5'd11, 16'h0000), 0, 0, 1, 5'd11, 32'd26);
`ifdef ID_WB_BYPASS_EN
    chk("haz.direct", Rdata1, 32'd26);
`else
    chk("haz.direct", Rdata1, 32'd5);
`endif
    step("haz_post", 1, mk_i(6'h08, 5'd11, 5'd0, 16'h0000), 0, 0, 0, 5'd0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      rins = $urandom;
      rins[31:26] = ops[$urandom_range(0, 7)];
      step($sformatf("rnd%0d", i), 1'($urandom), rins, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom), $urandom);
    end

    WE = 1'b1; Wadr = 5'd7; Wdata = 32'hDEAD_BEEF; in_valid = 1'b1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++)
      step($sformatf("post_rst_r%0d", i), 1, mk_r(5'(i), 5'(i), 5'(i), 6'h20), 0, 0, 0, 5'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
